// File: rtl/barrel_shift_arbiter.sv
// Round-robin front end that feeds one of two requesters into an external
// multi-cycle shifter and steers the registered result back to its owner.
module barrel_shift_arbiter #(
    parameter int unsigned SH_LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_res_n,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [7:0]  i_req0_data,
    input  logic [3:0]  i_req0_shift_emount,
    input  logic        i_req0_direction_right,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [7:0]  i_req1_data,
    input  logic [3:0]  i_req1_shift_emount,
    input  logic        i_req1_direction_right,
    output logic        o_rsp0_valid,
    output logic        o_rsp1_valid,
    output logic [15:0] o_rsp_out,
    output logic        o_sh_load,
    output logic [7:0]  o_sh_data,
    output logic [3:0]  o_sh_shift_emount,
    output logic        o_sh_direction_right,
    input  logic [15:0] i_sh_out,
    output logic        o_busy,
    output logic        o_grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        lastGrant_q, lastGrant_d;
    logic        grantId_q, grantId_d;
    logic [7:0]  cmdData_q, cmdData_d;
    logic [3:0]  cmdAmount_q, cmdAmount_d;
    logic        cmdRight_q, cmdRight_d;
    logic [15:0] rspOut_q, rspOut_d;

    logic        anyValid;
    logic        grantSel;

    // A lone request always wins; a tie goes to whoever was not served last.
    assign anyValid = i_req0_valid | i_req1_valid;
    assign grantSel = (i_req0_valid & i_req1_valid) ? ~lastGrant_q : i_req1_valid;

    // Next-state logic: accept in IDLE, strobe the shifter, count down its
    // latency, capture the result, then present it for a single cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lastGrant_d  = lastGrant_q;
        grantId_d    = grantId_q;
        cmdData_d    = cmdData_q;
        cmdAmount_d  = cmdAmount_q;
        cmdRight_d   = cmdRight_q;
        rspOut_d     = rspOut_q;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    state_d      = LOAD;
                    o_req0_ready = ~grantSel;
                    o_req1_ready = grantSel;
                    lastGrant_d  = grantSel;
                    grantId_d    = grantSel;
                    cmdData_d    = grantSel ? i_req1_data : i_req0_data;
                    cmdAmount_d  = grantSel ? i_req1_shift_emount : i_req0_shift_emount;
                    cmdRight_d   = grantSel ? i_req1_direction_right : i_req0_direction_right;
                end
            end
            LOAD: begin
                state_d = WAIT;
                cnt_d   = 4'(SH_LATENCY);
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = DONE;
                    rspOut_d = i_sh_out;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and command registers; reset leaves the pointer on requester 1
    // so requester 0 wins the first tie.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lastGrant_q <= 1'b1;
            grantId_q   <= 1'b0;
            cmdData_q   <= '0;
            cmdAmount_q <= '0;
            cmdRight_q  <= 1'b0;
            rspOut_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lastGrant_q <= lastGrant_d;
            grantId_q   <= grantId_d;
            cmdData_q   <= cmdData_d;
            cmdAmount_q <= cmdAmount_d;
            cmdRight_q  <= cmdRight_d;
            rspOut_q    <= rspOut_d;
        end
    end

    assign o_sh_load            = (state_q == LOAD);
    assign o_sh_data            = cmdData_q;
    assign o_sh_shift_emount    = cmdAmount_q;
    assign o_sh_direction_right = cmdRight_q;
    assign o_rsp0_valid         = (state_q == DONE) & ~grantId_q;
    assign o_rsp1_valid         = (state_q == DONE) & grantId_q;
    assign o_rsp_out            = rspOut_q;
    assign o_busy               = (state_q != IDLE);
    assign o_grant_id           = grantId_q;

endmodule
